tx_waveform_player: RTL

- Transmit-side counterpart of the rx sample buffer.
- Holds one transmit waveform of up to 1024 signed 32-bit samples, loaded through a write port.
- On a start command, streams the samples in address order, one per sample tick, to the TX DAC/modulator path.
- Sits between the control/loader logic and the TX front end. Reports busy, per-sample valid and end-of-burst done.

---
 rtl/tx_pkg.sv | 22 ++
 rtl/tx_BRAM_32_1024.sv | 30 +++
 rtl/tx_waveform_player.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/tx_pkg.sv
// Shared constants and types for the transmit waveform player.
package tx_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned DEPTH  = 1024;
  localparam int unsigned ADDR_W = 10;

  // Longest burst a single start can request; longer lengths saturate here.
  localparam logic [ADDR_W:0] LEN_MAX = (ADDR_W + 1)'(1024);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_PLAY  = 2'd2,
    ST_DONE  = 2'd3
  } tx_state_e;

  function automatic logic [ADDR_W:0] sat_len(input logic [ADDR_W:0] len);
    return (len > LEN_MAX) ? LEN_MAX : len;
  endfunction

endpackage

// File: rtl/tx_BRAM_32_1024.sv
// Simple dual-port waveform RAM: one clock, read-first, registered read data
// that holds its value whenever the read enable is low.
module tx_BRAM_32_1024
  import tx_pkg::*;
(
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Write port and registered read port; the read sees pre-write contents.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/tx_waveform_player.sv
// Streams a stored transmit waveform, one sample per DAC tick, after a start.
// Optional looping playback (istop/iloop ports) is enabled by TX_LOOP_EN.
module tx_waveform_player
  import tx_pkg::*;
(
  input  logic              ctx_clk,
  input  logic              rtx_rst,
  input  logic              etx_en,
  input  logic              iw_enable,
  input  logic [ADDR_W-1:0] iw_address,
  input  logic [DATA_W-1:0] idata_in,
  input  logic              istart,
  input  logic [ADDR_W:0]   ilength,
  input  logic              isample_tick,
`ifdef TX_LOOP_EN
  input  logic              istop,
  input  logic              iloop,
`endif
  output logic [DATA_W-1:0] odata_out,
  output logic              ovalid,
  output logic              obusy,
  output logic              odone
);

  localparam logic [ADDR_W:0]   CntOne  = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W-1:0] AddrOne = ADDR_W'(1);

  tx_state_e         state_q, state_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
`ifdef TX_LOOP_EN
  logic              loop_q, loop_d;
  logic              stop_q, stop_d;
  logic              pass_end_q, pass_end_d;
`endif

  tx_BRAM_32_1024 u_bram (
    .clk_i   (ctx_clk),
    .we_i    (etx_en & iw_enable),
    .waddr_i (iw_address),
    .wdata_i (idata_in),
    .re_i    (rd_en),
    .raddr_i (rd_addr),
    .rdata_o (rd_data)
  );

  // Next-state, prefetch control and registered-output values.
  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    rd_addr_d = rd_addr_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    done_d    = 1'b0;
    rd_en     = 1'b0;
    rd_addr   = rd_addr_q;
`ifdef TX_LOOP_EN
    loop_d     = loop_q;
    stop_d     = stop_q | istop;
    pass_end_d = 1'b0;
`endif

    unique case (state_q)
      ST_IDLE: begin
        if (istart && (ilength != '0)) begin
          len_d     = sat_len(ilength);
          cnt_d     = '0;
          rd_addr_d = '0;
          state_d   = ST_PRIME;
`ifdef TX_LOOP_EN
          loop_d = iloop;
          stop_d = 1'b0;
`endif
        end
      end
      ST_PRIME: begin
        // Fetch sample 0 so it is ready for the first tick; ticks here drop.
        rd_en     = 1'b1;
        rd_addr_d = rd_addr_q + AddrOne;
        state_d   = ST_PLAY;
      end
      ST_PLAY: begin
        if (isample_tick) begin
          data_d    = rd_data;
          valid_d   = 1'b1;
          rd_en     = 1'b1;
          rd_addr_d = rd_addr_q + AddrOne;
          cnt_d     = cnt_q + CntOne;
          if ((cnt_q + CntOne) == len_q) begin
`ifdef TX_LOOP_EN
            if (loop_q && !(stop_q || istop)) begin
              // Restart the pass without a gap: prefetch sample 0 now.
              cnt_d      = '0;
              rd_addr    = '0;
              rd_addr_d  = AddrOne;
              pass_end_d = 1'b1;
            end else begin
              state_d = ST_DONE;
            end
`else
            state_d = ST_DONE;
`endif
          end
        end
      end
      ST_DONE: begin
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

`ifdef TX_LOOP_EN
    if (pass_end_q) begin
      done_d = 1'b1;
    end
`endif

    busy_d = (state_d != ST_IDLE);

    if (!etx_en) begin
      state_d   = ST_IDLE;
      len_d     = '0;
      cnt_d     = '0;
      rd_addr_d = '0;
      data_d    = '0;
      valid_d   = 1'b0;
      busy_d    = 1'b0;
      done_d    = 1'b0;
      rd_en     = 1'b0;
`ifdef TX_LOOP_EN
      loop_d     = 1'b0;
      stop_d     = 1'b0;
      pass_end_d = 1'b0;
`endif
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge ctx_clk) begin
    if (rtx_rst) begin
      state_q   <= ST_IDLE;
      len_q     <= '0;
      cnt_q     <= '0;
      rd_addr_q <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef TX_LOOP_EN
      loop_q     <= 1'b0;
      stop_q     <= 1'b0;
      pass_end_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      rd_addr_q <= rd_addr_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
`ifdef TX_LOOP_EN
      loop_q     <= loop_d;
      stop_q     <= stop_d;
      pass_end_q <= pass_end_d;
`endif
    end
  end

  assign odata_out = data_q;
  assign ovalid    = valid_q;
  assign obusy     = busy_q;
  assign odone     = done_q;

endmodule
